rf_wb_arbiter: RTL

//  Shares the register file's single synchronous write port between two writeback sources.

---
 rtl/rf_wb_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-source writeback arbiter for the register file write port
module rf_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [4:0]            a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  l_valid,
  output logic                  l_ready,
  input  logic [4:0]            l_addr,
  input  logic [DATA_WIDTH-1:0] l_data,
  input  logic [2:0]            l_funct3,
  output logic                  rf_wr_en,
  output logic [4:0]            rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  input  logic [4:0]            chk_addr1,
  input  logic [4:0]            chk_addr2,
  output logic                  chk_busy1,
  output logic                  chk_busy2
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  logic [4:0]            a_addr_mem [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] a_data_mem [BUF_DEPTH];
  logic [4:0]            l_addr_mem [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] l_data_mem [BUF_DEPTH];

  logic [PW-1:0] a_wp, a_rp, l_wp, l_rp;
  logic [CW-1:0] a_cnt, l_cnt;
  logic          last_l;

  logic a_push, l_push, a_store, l_store;
  logic a_ne, l_ne, grant_a, grant_l, a_pop, l_pop;
  logic busy1_raw, busy2_raw;
  logic [DATA_WIDTH-1:0] l_ext;

  // Loads are widened on entry so the FIFO always holds final register data.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [2:0] f);
    case (f)
      3'b000:  return {{(DATA_WIDTH-8){d[7]}}, d[7:0]};
      3'b001:  return {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
      3'b100:  return {{(DATA_WIDTH-8){1'b0}}, d[7:0]};
      3'b101:  return {{(DATA_WIDTH-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Slot idx is occupied when its distance from the read pointer is below the count.
  function automatic logic occupied(input int idx, input logic [PW-1:0] rp,
                                    input logic [CW-1:0] cnt);
    logic [PW-1:0] off;
    off = PW'(idx) - rp;
    return {1'b0, off} < cnt;
  endfunction

  assign a_ready = !reset && (a_cnt < FULL);
  assign l_ready = !reset && (l_cnt < FULL);
  assign a_push  = a_valid && a_ready;
  assign l_push  = l_valid && l_ready;
  // Writes to x0 complete the handshake but are never stored.
  assign a_store = a_push && (a_addr != 5'd0);
  assign l_store = l_push && (l_addr != 5'd0);
  assign a_ne    = (a_cnt != '0);
  assign l_ne    = (l_cnt != '0);
  assign l_ext   = load_extend(l_data, l_funct3);

  // Round-robin grant: a lone non-empty FIFO wins, ties go to the source not granted last.
  always_comb begin
    grant_l = l_ne && (!a_ne || !last_l);
    grant_a = a_ne && !grant_l;
    a_pop   = grant_a && !reset;
    l_pop   = grant_l && !reset;
  end

  // Granted head drives the register file port; idle port is held at zero.
  always_comb begin
    rf_wr_en   = a_pop || l_pop;
    rf_wr_addr = 5'd0;
    rf_wr_data = '0;
    if (l_pop) begin
      rf_wr_addr = l_addr_mem[l_rp];
      rf_wr_data = l_data_mem[l_rp];
    end else if (a_pop) begin
      rf_wr_addr = a_addr_mem[a_rp];
      rf_wr_data = a_data_mem[a_rp];
    end
  end

  // Hazard check over every occupied slot, including the head being written this cycle.
  always_comb begin
    busy1_raw = 1'b0;
    busy2_raw = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (occupied(i, a_rp, a_cnt)) begin
        if (a_addr_mem[i] == chk_addr1) busy1_raw = 1'b1;
        if (a_addr_mem[i] == chk_addr2) busy2_raw = 1'b1;
      end
      if (occupied(i, l_rp, l_cnt)) begin
        if (l_addr_mem[i] == chk_addr1) busy1_raw = 1'b1;
        if (l_addr_mem[i] == chk_addr2) busy2_raw = 1'b1;
      end
    end
    chk_busy1 = !reset && (chk_addr1 != 5'd0) && busy1_raw;
    chk_busy2 = !reset && (chk_addr2 != 5'd0) && busy2_raw;
  end

  // FIFO storage; no reset needed since occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (a_store) begin
      a_addr_mem[a_wp] <= a_addr;
      a_data_mem[a_wp] <= a_data;
    end
    if (l_store) begin
      l_addr_mem[l_wp] <= l_addr;
      l_data_mem[l_wp] <= l_ext;
    end
  end

  // Pointer, count and round-robin state; reset leaves A as last winner so L wins the next tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_wp   <= '0;
      a_rp   <= '0;
      a_cnt  <= '0;
      l_wp   <= '0;
      l_rp   <= '0;
      l_cnt  <= '0;
      last_l <= 1'b0;
    end else begin
      if (a_store) a_wp <= a_wp + 1'b1;
      if (a_pop)   a_rp <= a_rp + 1'b1;
      if (l_store) l_wp <= l_wp + 1'b1;
      if (l_pop)   l_rp <= l_rp + 1'b1;
      case ({a_store, a_pop})
        2'b10:   a_cnt <= a_cnt + 1'b1;
        2'b01:   a_cnt <= a_cnt - 1'b1;
        default: a_cnt <= a_cnt;
      endcase
      case ({l_store, l_pop})
        2'b10:   l_cnt <= l_cnt + 1'b1;
        2'b01:   l_cnt <= l_cnt - 1'b1;
        default: l_cnt <= l_cnt;
      endcase
      if (a_pop || l_pop) last_l <= l_pop;
    end
  end

endmodule
